// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester (CPU, DMA) arbiter and access sequencer for a single-port data RAM.
// Each access is one RAM command cycle, an optional read-latency wait, then a one-cycle completion
// pulse. On contention the winner alternates, or the CPU always wins if ROUND_ROBIN is 0.
//
// Ports:
//   Clk, Rst                  clock (rising edge), synchronous active-high reset
//   CpuReq/Wr/Addr/WData      CPU request; attributes held stable while CpuReq is high
//   CpuGnt, CpuDone           one-cycle pulses: command on the RAM bus / access complete
//   CpuRData                  last CPU read data, held until the next CPU read completes
//   Dma*                      same set of signals for the DMA requester
//   RamCs/Wen/Oen/Address/DataIn  RAM command bus (all zero outside the command cycle)
//   RamDataOut                RAM read data
//   Busy                      high whenever the sequencer is not idle
// All outputs are driven straight from flops.
module ram_arbiter #(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 8,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          CpuReq,
  input  logic          CpuWr,
  input  logic [AW-1:0] CpuAddr,
  input  logic [DW-1:0] CpuWData,
  output logic          CpuGnt,
  output logic          CpuDone,
  output logic [DW-1:0] CpuRData,
  input  logic          DmaReq,
  input  logic          DmaWr,
  input  logic [AW-1:0] DmaAddr,
  input  logic [DW-1:0] DmaWData,
  output logic          DmaGnt,
  output logic          DmaDone,
  output logic [DW-1:0] DmaRData,
  output logic          RamCs,
  output logic          RamWen,
  output logic          RamOen,
  output logic [AW-1:0] RamAddress,
  output logic [DW-1:0] RamDataIn,
  input  logic [DW-1:0] RamDataOut,
  output logic          Busy
);

  localparam int unsigned CW = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  state_e        state_q, state_d;
  // Last granted requester (1 = DMA); during an access it also names the current owner.
  logic          sel_q, sel_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;

  logic          cpu_gnt_q, cpu_gnt_d;
  logic          dma_gnt_q, dma_gnt_d;
  logic          cpu_done_q, cpu_done_d;
  logic          dma_done_q, dma_done_d;
  logic          ram_cs_q, ram_cs_d;
  logic          ram_wen_q, ram_wen_d;
  logic          ram_oen_q, ram_oen_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          busy_q, busy_d;

  logic          pick_dma;

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    pick_dma    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (CpuReq || DmaReq) begin
          // DMA wins if alone, or on a tie when round-robin says the CPU went last.
          pick_dma = DmaReq && (!CpuReq || ((ROUND_ROBIN != 0) && !sel_q));
          sel_d    = pick_dma;
          wr_d     = pick_dma ? DmaWr    : CpuWr;
          addr_d   = pick_dma ? DmaAddr  : CpuAddr;
          wdata_d  = pick_dma ? DmaWData : CpuWData;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        if (wr_q) begin
          state_d = StDone;
        end else begin
          state_d = StWait;
          cnt_d   = CW'(RD_LATENCY);
        end
      end
      StWait: begin
        if (cnt_q == CW'(1)) begin
          state_d = StDone;
          if (sel_q) begin
            dma_rdata_d = RamDataOut;
          end else begin
            cpu_rdata_d = RamDataOut;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state so outputs are registered.
  always_comb begin
    ram_cs_d   = (state_d == StAccess);
    ram_wen_d  = ram_cs_d && wr_d;
    ram_oen_d  = ram_cs_d && !wr_d;
    ram_addr_d = ram_cs_d ? addr_d : '0;
    ram_din_d  = (ram_cs_d && wr_d) ? wdata_d : '0;
    cpu_gnt_d  = ram_cs_d && !sel_d;
    dma_gnt_d  = ram_cs_d && sel_d;
    cpu_done_d = (state_d == StDone) && !sel_d;
    dma_done_d = (state_d == StDone) && sel_d;
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      sel_q       <= 1'b1;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_oen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_gnt_q   <= cpu_gnt_d;
      dma_gnt_q   <= dma_gnt_d;
      cpu_done_q  <= cpu_done_d;
      dma_done_q  <= dma_done_d;
      ram_cs_q    <= ram_cs_d;
      ram_wen_q   <= ram_wen_d;
      ram_oen_q   <= ram_oen_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      busy_q      <= busy_d;
    end
  end

  assign CpuGnt     = cpu_gnt_q;
  assign CpuDone    = cpu_done_q;
  assign CpuRData   = cpu_rdata_q;
  assign DmaGnt     = dma_gnt_q;
  assign DmaDone    = dma_done_q;
  assign DmaRData   = dma_rdata_q;
  assign RamCs      = ram_cs_q;
  assign RamWen     = ram_wen_q;
  assign RamOen     = ram_oen_q;
  assign RamAddress = ram_addr_q;
  assign RamDataIn  = ram_din_q;
  assign Busy       = busy_q;

endmodule
